// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants, entry layout and trigger-level decode for the UART RX FIFO
package uart_rx_pkg;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int ENTRY_W = 11;
    localparam int PE_BIT  = 8;
    localparam int FE_BIT  = 9;
    localparam int BI_BIT  = 10;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } trig_lvl_e;

    function automatic logic [4:0] trig_decode(input logic [1:0] lvl);
        logic [4:0] n;
        case (trig_lvl_e'(lvl))
            TRIG_1:  n = 5'd1;
            TRIG_4:  n = 5'd4;
            TRIG_8:  n = 5'd8;
            default: n = 5'd14;
        endcase
        return n;
    endfunction
endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - character-timeout counter, present only when UART_RX_TIMEOUT_EN is defined
module uart_rx_timeout #(
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic char_tick,
    input  logic empty,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT_CHARS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(TIMEOUT_CHARS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || empty) begin
            cnt_d = '0;
        end else if (char_tick && cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Built from the next count so an accepted push/pop drops timeout on the same edge.
        timeout_d = (cnt_d == MAX_CNT) && !empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with line-error tracking, trigger level and optional timeout (UART_RX_TIMEOUT_EN)
module uart_rx_fifo #(
    parameter int DEPTH         = uart_rx_pkg::DEPTH,
    parameter int AW            = uart_rx_pkg::AW,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        push_in,
    input  logic        pop_in,
    input  logic [7:0]  din,
    input  logic        pe_in,
    input  logic        fe_in,
    input  logic        bi_in,
    input  logic [1:0]  trig_lvl,
    input  logic        char_tick,
    output logic [7:0]  dout,
    output logic        dout_pe,
    output logic        dout_fe,
    output logic        dout_bi,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count,
    output logic        overrun,
    output logic        underrun,
    output logic        rx_trigger,
    output logic        err_in_fifo,
    output logic        timeout
);
    import uart_rx_pkg::*;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d, err_cnt_q, err_cnt_d;
    logic               overrun_q, overrun_d, underrun_q, underrun_d;
    logic               rx_trigger_q, rx_trigger_d;
    logic               push, pop, push_err, head_err;
    logic [ENTRY_W-1:0] head;

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    always_comb begin
        pop      = pop_in && en && !empty;
        push     = push_in && en && (!full || pop);
        push_err = pe_in || fe_in || bi_in;
        head_err = head[PE_BIT] || head[FE_BIT] || head[BI_BIT];

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        err_cnt_d = err_cnt_q;
        case ({push && push_err, pop && head_err})
            2'b10:   err_cnt_d = err_cnt_q + (AW + 1)'(1);
            2'b01:   err_cnt_d = err_cnt_q - (AW + 1)'(1);
            default: err_cnt_d = err_cnt_q;
        endcase

        overrun_d    = push_in && en && full && !pop_in;
        underrun_d   = pop_in && en && empty;
        rx_trigger_d = (count_q >= trig_decode(trig_lvl));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_cnt_q    <= '0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            rx_trigger_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_cnt_q    <= err_cnt_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
            rx_trigger_q <= rx_trigger_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {bi_in, fe_in, pe_in, din};
        end
    end

    assign dout        = head[7:0];
    assign dout_pe     = head[PE_BIT];
    assign dout_fe     = head[FE_BIT];
    assign dout_bi     = head[BI_BIT];
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;
    assign rx_trigger  = rx_trigger_q;
    assign err_in_fifo = (err_cnt_q != '0);

`ifdef UART_RX_TIMEOUT_EN
    uart_rx_timeout #(
        .TIMEOUT_CHARS(TIMEOUT_CHARS)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (push || pop),
        .char_tick (char_tick),
        .empty     (empty),
        .timeout   (timeout)
    );
`else
    logic unused_tick;
    assign unused_tick = char_tick ^ (TIMEOUT_CHARS == 0);
    assign timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n, en, push_in, pop_in, pe_in, fe_in, bi_in, char_tick;
    logic [7:0] din;
    logic [1:0] trig_lvl;
    logic [7:0] dout;
    logic       dout_pe, dout_fe, dout_bi, empty, full;
    logic [4:0] count;
    logic       overrun, underrun, rx_trigger, err_in_fifo, timeout;

    int n_checks = 0;
    int n_fails  = 0;

    uart_rx_fifo dut (
        .clk(clk), .rst_n(rst_n), .en(en), .push_in(push_in), .pop_in(pop_in),
        .din(din), .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in),
        .trig_lvl(trig_lvl), .char_tick(char_tick),
        .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi),
        .empty(empty), .full(full), .count(count),
        .overrun(overrun), .underrun(underrun), .rx_trigger(rx_trigger),
        .err_in_fifo(err_in_fifo), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic fe);
        push_in = 1'b1;
        din     = d;
        fe_in   = fe;
        step();
        push_in = 1'b0;
        fe_in   = 1'b0;
    endtask

    task automatic pop();
        pop_in = 1'b1;
        step();
        pop_in = 1'b0;
    endtask

    initial begin
        en = 1'b1; push_in = 1'b0; pop_in = 1'b0; din = 8'h00;
        pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0; char_tick = 1'b0;
        trig_lvl = 2'b11;
        do_reset();

        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_underrun", underrun, 0);
        check("rst_trigger", rx_trigger, 0);
        check("rst_err", err_in_fifo, 0);
        check("rst_timeout", timeout, 0);

        // Fill and drain twice; second pass exercises pointer wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) push(8'h41 + 8'(i), 1'b0);
            check("fill_full", full, 1);
            check("fill_count", count, 16);
            for (int i = 0; i < 16; i++) begin
                check("drain_dout", dout, 8'h41 + 8'(i));
                pop();
            end
            check("drain_empty", empty, 1);
        end

        // Overrun on full, then simultaneous push/pop on full.
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i), 1'b0);
        push(8'h99, 1'b0);
        check("ovr_pulse", overrun, 1);
        check("ovr_count", count, 16);
        step();
        check("ovr_clear", overrun, 0);
        push_in = 1'b1; pop_in = 1'b1; din = 8'h77;
        step();
        push_in = 1'b0; pop_in = 1'b0;
        check("pp_full_count", count, 16);
        check("pp_full_no_ovr", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            check("pp_drain_dout", dout, (i < 15) ? 8'h31 + 8'(i) : 8'h77);
            pop();
        end
        check("pp_drain_empty", empty, 1);

        // Underrun on empty.
        pop();
        check("udr_pulse", underrun, 1);
        check("udr_count", count, 0);
        step();
        check("udr_clear", underrun, 0);

        // Simultaneous push/pop on empty: only the push lands.
        push_in = 1'b1; pop_in = 1'b1; din = 8'h12;
        step();
        push_in = 1'b0; pop_in = 1'b0;
        check("pp_empty_count", count, 1);
        check("pp_empty_dout", dout, 8'h12);
        pop();
        check("pp_empty_drained", empty, 1);

        // Disabled FIFO ignores requests and raises no error pulses.
        en = 1'b0;
        push(8'hEE, 1'b0);
        check("dis_count", count, 0);
        pop();
        check("dis_no_udr", underrun, 0);
        en = 1'b1;

        // Trigger level 8.
        trig_lvl = 2'b10;
        for (int i = 0; i < 7; i++) push(8'h60 + 8'(i), 1'b0);
        step();
        check("trig_7", rx_trigger, 0);
        push(8'h67, 1'b0);
        check("trig_8_same", rx_trigger, 0);
        step();
        check("trig_8_next", rx_trigger, 1);
        trig_lvl = 2'b11;
        step();
        check("trig_14", rx_trigger, 0);

        // Reset mid-burst discards everything.
        do_reset();
        check("rst_mid_count", count, 0);
        check("rst_mid_empty", empty, 1);

        // Error tracking.
        push(8'h55, 1'b1);
        push(8'h66, 1'b0);
        check("err_set", err_in_fifo, 1);
        check("err_head", dout, 8'h55);
        check("err_head_fe", dout_fe, 1);
        pop();
        check("err_clear", err_in_fifo, 0);
        check("err_next", dout, 8'h66);
        check("err_next_fe", dout_fe, 0);
        pop();

        // Character timeout.
        push(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("to_pre", timeout, 0);
            char_tick = 1'b1;
            step();
            char_tick = 1'b0;
        end
`ifdef UART_RX_TIMEOUT_EN
        check("to_set", timeout, 1);
        pop();
        check("to_pop_clear", timeout, 0);
        push(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            char_tick = 1'b1;
            step();
            char_tick = 1'b0;
        end
        do_reset();
        check("to_rst", timeout, 0);
        char_tick = 1'b1;
        step();
        char_tick = 1'b0;
        check("to_rst_after", timeout, 0);
`else
        check("to_tied", timeout, 0);
        pop();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side FIFO of the UART core: buffers characters produced by the RX deserializer until the host reads them over the register interface. It is the counterpart of the transmit FIFO. Each entry holds an 8-bit character and its per-character line errors: parity, framing, and break. The block also generates the receive-data-available trigger, the error-in-FIFO status, and the character-timeout indication.

## Interface
- `DEPTH`, 16, number of entries; power of two.
- `AW`, 4, pointer width, log2(DEPTH).
- `TIMEOUT_CHARS`, 4, character times of inactivity before `timeout` asserts.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: FIFO enable; when 0, push/pop requests are ignored.
- `push_in` in 1: deserializer write request, one cycle per received character.
- `pop_in` in 1: host read request.
- `din` in 8: received character.
- `pe_in`, `fe_in`, `bi_in` in 1 each: parity error, framing error, and break flags for `din`.
- `trig_lvl` in 2: trigger level; 00=1, 01=4, 10=8, 11=14 entries.
- `char_tick` in 1: one-cycle pulse once per character time, from the baud generator.
- `dout` out 8: head character.
- `dout_pe`, `dout_fe`, `dout_bi` out 1 each: error flags of the head entry.
- `empty`, `full` out 1 each: occupancy status.
- `count` out 5: number of valid entries, 0..16.
- `overrun`, `underrun` out 1 each: one-cycle registered error pulses.
- `rx_trigger` out 1: registered, high when `count` ≥ the selected trigger level.
- `err_in_fifo` out 1: high while any stored entry has PE, FE, or BI set.
- `timeout` out 1: character-timeout indication.

## Operation
- **Storage.** Circular buffer of DEPTH × 11 bits, with `wr_ptr` and `rd_ptr` of AW bits that wrap naturally.
  - `count` is a separate 5-bit counter.
  - `empty` = (count==0) and `full` = (count==DEPTH); both are combinational from `count`.
- **Head read.** `dout` and the three flags are driven combinationally from mem[rd_ptr]. They are valid only when `!empty`.
- **Accepted pop:** pop = pop_in & en & !empty.
- **Accepted push:** push = push_in & en & (!full | pop).
  - A push to a full FIFO is accepted only when a pop is accepted in the same cycle.
- **Push+pop in the same cycle.** Both pointers advance and `count` is unchanged.
  - When empty, only the push takes effect.
- **overrun.** Asserted on the cycle after push_in & en & full & !pop_in. The incoming character is discarded and FIFO contents are unchanged.
- **underrun.** Asserted on the cycle after pop_in & en & empty.
- **Error counter.** `err_cnt` (5 bits) counts stored entries with any error flag set.
  - Increments on an accepted push with (pe|fe|bi).
  - Decrements on an accepted pop whose head has any flag set.
  - Both in one cycle leave it unchanged.
  - `err_in_fifo` = (err_cnt != 0), combinational.
- **rx_trigger.** Registered compare of `count` against the decoded level. Evaluated every cycle, independent of `en`.
- **en=0.** The FIFO holds its state; `overrun` and `underrun` are not generated.
- **Reset.** Clears pointers, `count`, `err_cnt`, `overrun`, `underrun`, `rx_trigger`, the timeout counter, and `timeout`. Memory contents are not cleared. A reset mid-burst discards all entries.

## Timing
- **Reset values:** `empty`=1, `full`=0, `count`=0, `overrun`=0, `underrun`=0, `rx_trigger`=0, `err_in_fifo`=0, `timeout`=0. `dout` is undefined.
- **Push latency.** A push at edge N makes the data visible on `dout` after edge N when the FIFO was empty. `count` and `empty` update at edge N.
- **Pop.** The next head is visible in the cycle after the pop edge.
- **Trigger and error pulses.** `rx_trigger`, `overrun`, and `underrun` lag the causing condition by exactly one cycle.
- **Timeout.** Follows the `char_tick` rule below; `timeout` is registered.

## Configuration
- Macro: `UART_RX_TIMEOUT_EN`.
- **When defined:**
  - A counter (0..TIMEOUT_CHARS) clears on any accepted push or pop, and while the FIFO is empty.
  - Otherwise it increments on `char_tick` and saturates at TIMEOUT_CHARS.
  - `timeout` is registered: (cnt==TIMEOUT_CHARS) & !empty.
  - `timeout` deasserts the cycle after the next accepted push or pop.
- **When undefined:** `timeout` is tied to 0, `char_tick` is unused, and no counter logic is generated.

## Structure
- **Package `uart_rx_pkg`:**
  - `DEPTH`, `AW`, and the entry width (11).
  - Bit positions of PE/FE/BI within an entry.
  - `trig_lvl` encodings and the decode function returning 1/4/8/14.
- **Sub-module `uart_rx_timeout`:** the character-timeout counter. It is instantiated only under `UART_RX_TIMEOUT_EN`.

## Test plan
- **Fill and drain:** after reset, push 0x41..0x50 (16 chars) → `full`=1 and `count`=16. Then pop ×16 → `dout` sequence 0x41..0x50 and `empty`=1. Run the sequence twice to cover pointer wrap.
- **Overrun and underrun:**
  - With the FIFO full, push 0x99 → `overrun` pulses 1 cycle and a drain shows no 0x99.
  - With the FIFO empty, pop → `underrun` pulses 1 cycle and `count` stays 0.
- **Simultaneous push/pop:**
  - Full + push 0x77 + pop → `count` stays 16, no overrun, and 0x77 is the last entry drained.
  - Empty + push 0x12 + pop → `count`=1 and `dout`=0x12.
- **Trigger levels:** `trig_lvl`=10, push 7 chars → `rx_trigger`=0; the 8th push → `rx_trigger`=1 one cycle later. Switching to 11 → 0 the next cycle.
- **Error tracking:** push 0x55 with `fe_in`=1, then 0x66 clean → `err_in_fifo`=1. Pop → `dout_fe`=1 seen on the first entry, and `err_in_fifo`=0 after the pop.
- **Timeout (macro defined):** push 1 char, then 4 `char_tick` pulses → `timeout`=1. A pop clears it the next cycle, and a reset mid-count leaves `timeout`=0.
